// File: rtl/stopwatch_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_disp_pkg
// Description : Shared types and constants for the stopwatch 4-digit
//               7-segment display driver: display modes, converter FSM
//               states, active-low segment codes and the BCD iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_disp_pkg;

  // Display modes (mode_sel encoding)
  localparam logic [1:0] MODE_HHMM = 2'b00;
  localparam logic [1:0] MODE_MMSS = 2'b01;
  localparam logic [1:0] MODE_SSCC = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Snapshot/convert/commit sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_L  = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_LOAD_R  = 3'd3,
    ST_SHIFT_R = 3'd4,
    ST_COMMIT  = 3'd5
  } disp_state_t;

  // Segment codes {g,f,e,d,c,b,a}, active-low (1 = segment off)
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Converter geometry: 12-bit binary in, four BCD nibbles out
  localparam int BIN_W    = 12;
  localparam int BCD_W    = 16;
  localparam int BCD_ITER = 12;

  // BCD nibble to segment pattern; non-decimal nibbles render blank
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential shift-and-add-3 (double-dabble) converter.
//               A start pulse loads the binary operand; the following
//               BCD_ITER cycles each perform one adjust+shift. done_o is high
//               during the cycle whose clock edge performs the final shift,
//               so bcd_o holds the finished result from the next cycle on.
// Ports       : clk_in  - clock
//               resetn  - asynchronous active-low reset
//               start   - load bin_i and begin converting
//               bin_i   - 12-bit binary operand
//               bcd_o   - 4 BCD nibbles {thousands,hundreds,tens,units}
//               done_o  - final-shift indication
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import stopwatch_disp_pkg::*;
(
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic [BCD_W-1:0] w_adj;

  // Add 3 to every nibble >= 5 so the following shift carries correctly
  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                              (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_bin  <= bin_i;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt + 4'd1;
      if (r_cnt == 4'(BCD_ITER - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bcd_o  = r_bcd;
  assign done_o = r_busy && (r_cnt == 4'(BCD_ITER - 1));

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_driver
// Description : Drives a 4-digit multiplexed 7-segment display from the
//               stopwatch counter. Each refresh frame one field pair chosen by
//               mode_sel is snapshotted, converted to BCD by a shared
//               sequential converter (left field, then right field), and the
//               four digit patterns are committed together.
// Ports       : clk_in    - system clock
//               resetn    - asynchronous active-low reset
//               mode_sel  - 00 HH:MM, 01 MM:SS, 10 SS.cc, 11 blank
//               Hours_i, Minutes_i, Seconds_i - 8-bit binary fields
//               milli_i   - milliseconds 0..999
//               an_o      - digit enables, active-low, an_o[3] leftmost
//               seg_o     - segments {g,f,e,d,c,b,a}, active-low
//               dp_o      - decimal point, active-low
//               frame_o   - one-cycle pulse when the scan wraps 3->0
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display_driver
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk_in,
  input  logic        resetn,
  input  logic [1:0]  mode_sel,
  input  logic [7:0]  Hours_i,
  input  logic [7:0]  Minutes_i,
  input  logic [7:0]  Seconds_i,
  input  logic [11:0] milli_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // --------------------------------------------------------------------------
  // Digit scan
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_idx;
  logic             r_frame;
  logic             w_scan_end;
  logic             w_wrap;
  logic [1:0]       w_idx_nxt;

  assign w_scan_end = (r_scan_cnt == CNT_LAST);
  assign w_idx_nxt  = w_scan_end ? (r_idx + 2'd1) : r_idx;
  assign w_wrap     = w_scan_end && (r_idx == 2'd3);

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
      r_frame    <= 1'b0;
    end else begin
      r_scan_cnt <= w_scan_end ? '0 : (r_scan_cnt + CNT_W'(1));
      r_idx      <= w_idx_nxt;
      r_frame    <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Field pair selection for the snapshot
  // --------------------------------------------------------------------------
  logic [7:0]  w_left_sel;
  logic [11:0] w_right_sel;

  always_comb begin
    w_left_sel  = '0;
    w_right_sel = '0;
    case (mode_sel)
      MODE_HHMM: begin
        w_left_sel  = Hours_i;
        w_right_sel = {4'd0, Minutes_i};
      end
      MODE_MMSS: begin
        w_left_sel  = Minutes_i;
        w_right_sel = {4'd0, Seconds_i};
      end
      MODE_SSCC: begin
        w_left_sel  = Seconds_i;
        w_right_sel = milli_i;
      end
      default: begin
        w_left_sel  = '0;
        w_right_sel = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared BCD converter
  // --------------------------------------------------------------------------
  disp_state_t      r_state;
  logic [1:0]       r_snap_mode;
  logic [7:0]       r_left_bin;
  logic [11:0]      r_right_bin;
  logic [7:0]       r_left_bcd;
  logic             w_conv_start;
  logic [BIN_W-1:0] w_conv_bin;
  logic [BCD_W-1:0] w_conv_bcd;
  logic             w_conv_done;

  assign w_conv_start = (r_state == ST_LOAD_L) || (r_state == ST_LOAD_R);
  assign w_conv_bin   = (r_state == ST_LOAD_L) ? {4'd0, r_left_bin} : r_right_bin;

  bin2bcd_seq u_bin2bcd (
    .clk_in (clk_in),
    .resetn (resetn),
    .start  (w_conv_start),
    .bin_i  (w_conv_bin),
    .bcd_o  (w_conv_bcd),
    .done_o (w_conv_done)
  );

  // --------------------------------------------------------------------------
  // Digit pattern build, evaluated while in COMMIT
  // --------------------------------------------------------------------------
  logic            w_milli;
  logic            w_left_over;
  logic            w_right_over;
  logic [3:0]      w_right_hi;
  logic [3:0]      w_right_lo;
  logic [3:0][6:0] w_new_digits;

  assign w_milli     = (r_snap_mode == MODE_SSCC);
  assign w_left_over = (r_left_bin > 8'd99);
  // Milliseconds above 999 show up as a non-zero thousands nibble
  assign w_right_over = w_milli ? (w_conv_bcd[15:12] != 4'd0)
                                : (r_right_bin > 12'd99);
  // cc = hundreds/tens of the millisecond value (truncation, no rounding)
  assign w_right_hi = w_milli ? w_conv_bcd[11:8] : w_conv_bcd[7:4];
  assign w_right_lo = w_milli ? w_conv_bcd[7:4]  : w_conv_bcd[3:0];

  always_comb begin
    w_new_digits = {4{SEG_BLANK}};
    if (r_snap_mode != MODE_OFF) begin
      w_new_digits[3] = w_left_over  ? SEG_DASH : seg_of(r_left_bcd[7:4]);
      w_new_digits[2] = w_left_over  ? SEG_DASH : seg_of(r_left_bcd[3:0]);
      w_new_digits[1] = w_right_over ? SEG_DASH : seg_of(w_right_hi);
      w_new_digits[0] = w_right_over ? SEG_DASH : seg_of(w_right_lo);
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot / convert / commit sequencer
  // --------------------------------------------------------------------------
  logic [3:0][6:0] r_digits;
  logic [1:0]      r_disp_mode;

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_snap_mode <= MODE_OFF;
      r_left_bin  <= '0;
      r_right_bin <= '0;
      r_left_bcd  <= '0;
      r_digits    <= {4{SEG_BLANK}};
      r_disp_mode <= MODE_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A frame pulse seen outside IDLE is simply dropped
          if (r_frame) begin
            r_snap_mode <= mode_sel;
            r_left_bin  <= w_left_sel;
            r_right_bin <= w_right_sel;
            r_state     <= ST_LOAD_L;
          end
        end
        ST_LOAD_L: begin
          r_state <= ST_SHIFT_L;
        end
        ST_SHIFT_L: begin
          if (w_conv_done) begin
            r_state <= ST_LOAD_R;
          end
        end
        ST_LOAD_R: begin
          // Left result is final here; the converter is reloaded this edge
          r_left_bcd <= w_conv_bcd[7:0];
          r_state    <= ST_SHIFT_R;
        end
        ST_SHIFT_R: begin
          if (w_conv_done) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_digits    <= w_new_digits;
          r_disp_mode <= r_snap_mode;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output registers, driven from the next scan index so they track an_o
  // --------------------------------------------------------------------------
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << w_idx_nxt);
      r_seg <= r_digits[w_idx_nxt];
      r_dp  <= ~((w_idx_nxt == 2'd2) && (r_disp_mode != MODE_OFF));
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign frame_o = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display_driver
// Description : Self-checking bench for stopwatch_display_driver (SCAN_DIV=8).
//               Table of {mode, fields, expected digit patterns} plus
//               hand-written sequences for reset, snapshot hold and
//               reset-during-conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_driver;

  logic        clk_in = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  mode_sel = 2'b01;
  logic [7:0]  hours = 8'd0;
  logic [7:0]  minutes = 8'd12;
  logic [7:0]  seconds = 8'd34;
  logic [11:0] milli = 12'd0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  always #5 clk_in = ~clk_in;

  stopwatch_display_driver #(.SCAN_DIV(8)) dut (
    .clk_in    (clk_in),
    .resetn    (resetn),
    .mode_sel  (mode_sel),
    .Hours_i   (hours),
    .Minutes_i (minutes),
    .Seconds_i (seconds),
    .milli_i   (milli),
    .an_o      (an_o),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .frame_o   (frame_o)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] h, m, s;
    logic [11:0] ms;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (frame_o === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_o not seen within 40 cycles", name);
    end
  endtask

  task automatic compare_pop(input string name, input int k);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: scoreboard empty", name, k);
    end else begin
      e = sb_q.pop_front();
      if (an_o !== e.an || seg_o !== e.seg || dp_o !== e.dp) begin
        errors++;
        $display("FAIL %s[%0d]: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                 name, k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
      end
    end
  endtask

  // Called at the frame_o cycle: checks the first ndig digit slots mid-dwell
  task automatic sample_digits(input string name, input logic [1:0] mode,
                               input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0,
                               input int ndig);
    logic [6:0] e [4];
    exp_t       x;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < ndig; k++) begin
      x.an  = ~(4'b0001 << k);
      x.seg = e[k];
      x.dp  = (k == 2 && mode != 2'b11) ? 1'b0 : 1'b1;
      sb_q.push_back(x);
    end
    for (int k = 0; k < ndig; k++) begin
      repeat ((k == 0) ? 4 : 8) tick();
      compare_pop(name, k);
    end
  endtask

  task automatic run_vec(input vec_t v);
    mode_sel = v.mode;
    hours    = v.h;
    minutes  = v.m;
    seconds  = v.s;
    milli    = v.ms;
    wait_frame({v.name, "_latch"});
    wait_frame({v.name, "_show"});
    sample_digits(v.name, v.mode, v.e3, v.e2, v.e1, v.e0, 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{"mmss_1234",   2'b01, 8'd0,   8'd12,  8'd34, 12'd0,    7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1]  = '{"sscc_5998",   2'b10, 8'd0,   8'd0,   8'd59, 12'd987,  7'h12, 7'h10, 7'h10, 7'h00};
    vecs[2]  = '{"sscc_ms0",    2'b10, 8'd0,   8'd0,   8'd59, 12'd0,    7'h12, 7'h10, 7'h40, 7'h40};
    vecs[3]  = '{"hhmm_m100",   2'b00, 8'd0,   8'd100, 8'd0,  12'd0,    7'h40, 7'h40, 7'h3F, 7'h3F};
    vecs[4]  = '{"sscc_ms1000", 2'b10, 8'd0,   8'd0,   8'd5,  12'd1000, 7'h40, 7'h12, 7'h3F, 7'h3F};
    vecs[5]  = '{"hhmm_2359",   2'b00, 8'd23,  8'd59,  8'd0,  12'd0,    7'h24, 7'h30, 7'h12, 7'h10};
    vecs[6]  = '{"hhmm_h200",   2'b00, 8'd200, 8'd7,   8'd0,  12'd0,    7'h3F, 7'h3F, 7'h40, 7'h78};
    vecs[7]  = '{"off",         2'b11, 8'd1,   8'd2,   8'd3,  12'd4,    7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[8]  = '{"mmss_0009",   2'b01, 8'd0,   8'd0,   8'd9,  12'd0,    7'h40, 7'h40, 7'h40, 7'h10};
    vecs[9]  = '{"sscc_9999",   2'b10, 8'd0,   8'd0,   8'd99, 12'd999,  7'h10, 7'h10, 7'h10, 7'h10};
    vecs[10] = '{"mmss_m100",   2'b01, 8'd0,   8'd100, 8'd99, 12'd0,    7'h3F, 7'h3F, 7'h10, 7'h10};

    // ---- Reset state and first scan ----
    repeat (3) tick();
    chk("rst_an", an_o, 4'hF);
    chk("rst_seg", seg_o, 7'h7F);
    chk("rst_dp", dp_o, 1'b1);
    chk("rst_frame", frame_o, 1'b0);
    resetn = 1'b1;
    tick();
    chk("scan_an0", an_o, 4'b1110);
    chk("scan_seg_blank", seg_o, 7'h7F);
    repeat (11) tick();
    chk("scan_an1", an_o, 4'b1101);
    repeat (8) tick();
    chk("scan_an2", an_o, 4'b1011);
    chk("scan_dp_off_pre_commit", dp_o, 1'b1);
    repeat (8) tick();
    chk("scan_an3", an_o, 4'b0111);
    n = 28;
    while (frame_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("first_frame_cycle", n, 32);
    tick();
    chk("frame_pulse_width", frame_o, 1'b0);
    repeat (19) tick();                 // T20 of the frame: still before COMMIT
    chk("pre_commit_blank", seg_o, 7'h7F);
    repeat (10) tick();                 // T30: committed digit 3 = '1'
    chk("post_commit_an", an_o, 4'b0111);
    chk("post_commit_seg", seg_o, 7'h79);

    // ---- Table-driven vectors ----
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // ---- Mid-frame changes held until the next COMMIT ----
    run_vec(vecs[0]);
    wait_frame("hold_latch_old");
    repeat (3) tick();
    mode_sel = 2'b00;
    hours    = 8'd7;
    minutes  = 8'd45;
    sample_digits("hold_same_frame", 2'b01, 7'h79, 7'h24, 7'h30, 7'h19, 3);
    wait_frame("hold_latch_new");
    sample_digits("hold_pre_commit", 2'b01, 7'h79, 7'h24, 7'h30, 7'h19, 3);
    wait_frame("hold_show_new");
    sample_digits("hold_new_hhmm", 2'b00, 7'h40, 7'h78, 7'h19, 7'h12, 4);

    // ---- Reset asserted during the right-field conversion ----
    wait_frame("midrst_frame");
    repeat (20) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_an", an_o, 4'hF);
    chk("midrst_seg", seg_o, 7'h7F);
    chk("midrst_dp", dp_o, 1'b1);
    chk("midrst_frame", frame_o, 1'b0);
    repeat (2) tick();
    resetn = 1'b1;
    run_vec(vecs[1]);
    run_vec(vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
